// File: rtl/elevador_pkg.sv
// Shared elevator definitions: default sizing and the access-window state encoding.
package elevador_pkg;
    localparam int N_ANDARES_DEF      = 16;
    localparam int ANDAR_RESTRITO_DEF = 6;
    localparam int TEMPO_ACESSO_DEF   = 8;

    typedef enum logic {OCIOSO, LIBERADO} estado_acesso_t;
endpackage

// File: rtl/registro_chamadas_if.sv
// Panel/controller side of the call register: button presses in, call status out.
interface registro_chamadas_if #(
    parameter int N_ANDARES = 16,
    parameter int AW        = $clog2(N_ANDARES)
);
    logic [N_ANDARES-1:0] botao;
    logic                 checagem;
    logic [AW-1:0]        andar_atual;
    logic                 parada;
    logic [N_ANDARES-1:0] chamadas;
    logic                 acesso_liberado;
    logic                 negado;
    logic                 pendente;
    logic                 pedido_acima;
    logic                 pedido_abaixo;
    logic                 pedido_aqui;

    modport master (
        output botao, checagem, andar_atual, parada,
        input  chamadas, acesso_liberado, negado, pendente,
               pedido_acima, pedido_abaixo, pedido_aqui
    );

    modport slave (
        input  botao, checagem, andar_atual, parada,
        output chamadas, acesso_liberado, negado, pendente,
               pedido_acima, pedido_abaixo, pedido_aqui
    );
endinterface

// File: rtl/janela_acesso.sv
// Authorization window for restricted floors; a single accepted restricted press closes it.
module janela_acesso
    import elevador_pkg::*;
#(
    parameter int TEMPO_ACESSO = TEMPO_ACESSO_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic checagem,
    input  logic consumir,
    output logic auth,
    output logic acesso_liberado
);
    localparam int            CW    = (TEMPO_ACESSO > 1) ? $clog2(TEMPO_ACESSO) : 1;
    localparam logic [CW-1:0] CARGA = CW'(TEMPO_ACESSO - 1);

    estado_acesso_t estado, estado_nxt;
    logic [CW-1:0]  contador, contador_nxt;

    // checagem authorizes its own cycle so a press arriving with the credential is not lost
    assign auth = (estado == LIBERADO) | checagem;

    always_comb begin
        estado_nxt   = estado;
        contador_nxt = contador;
        case (estado)
            OCIOSO: begin
                if (checagem && !consumir) begin
                    estado_nxt   = LIBERADO;
                    contador_nxt = CARGA;
                end
            end
            LIBERADO: begin
                if (consumir) begin
                    estado_nxt   = OCIOSO;
                    contador_nxt = '0;
                end else if (checagem) begin
                    contador_nxt = CARGA;
                end else if (contador == '0) begin
                    estado_nxt = OCIOSO;
                end else begin
                    contador_nxt = contador - CW'(1);
                end
            end
            default: begin
                estado_nxt   = OCIOSO;
                contador_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado          <= OCIOSO;
            contador        <= '0;
            acesso_liberado <= 1'b0;
        end else begin
            estado          <= estado_nxt;
            contador        <= contador_nxt;
            acesso_liberado <= (estado_nxt == LIBERADO);
        end
    end
endmodule

// File: rtl/registro_chamadas.sv
// Elevator call register: latches permitted presses, clears served floors, reports direction.
module registro_chamadas
    import elevador_pkg::*;
#(
    parameter int N_ANDARES      = N_ANDARES_DEF,
    parameter int ANDAR_RESTRITO = ANDAR_RESTRITO_DEF,
    parameter int TEMPO_ACESSO   = TEMPO_ACESSO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    registro_chamadas_if.slave bus
);
    localparam int AW = $clog2(N_ANDARES);

    logic [N_ANDARES-1:0] chamadas_q, chamadas_nxt;
    logic [N_ANDARES-1:0] restrito, acima, abaixo, aqui;
    logic [N_ANDARES-1:0] aceito, limpar;
    logic                 auth, consumir, rejeitado, negado_q, liberado;

    // Per-floor masks; an out-of-range andar_atual leaves every floor "below" and none "here"
    for (genvar i = 0; i < N_ANDARES; i++) begin : g_mascara
        assign restrito[i] = (i >= ANDAR_RESTRITO);
        assign acima[i]    = (32'(i) > 32'(bus.andar_atual));
        assign abaixo[i]   = (32'(i) < 32'(bus.andar_atual));
        assign aqui[i]     = (32'(i) == 32'(bus.andar_atual));
    end

    assign aceito    = bus.botao & (~restrito | {N_ANDARES{auth}});
    assign consumir  = |(aceito & restrito);
    assign rejeitado = |(bus.botao & restrito) & ~auth;
    assign limpar    = aqui & {N_ANDARES{bus.parada}};

    // Clear wins over a same-cycle press: the car is already serving that floor
    assign chamadas_nxt = (chamadas_q | aceito) & ~limpar;

    janela_acesso #(.TEMPO_ACESSO(TEMPO_ACESSO)) u_janela (
        .clk             (clk),
        .rst             (rst),
        .checagem        (bus.checagem),
        .consumir        (consumir),
        .auth            (auth),
        .acesso_liberado (liberado)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            chamadas_q <= '0;
            negado_q   <= 1'b0;
        end else begin
            chamadas_q <= chamadas_nxt;
            negado_q   <= rejeitado;
        end
    end

    assign bus.chamadas        = chamadas_q;
    assign bus.acesso_liberado = liberado;
    assign bus.negado          = negado_q;
    assign bus.pendente        = |chamadas_q;
    assign bus.pedido_acima    = |(chamadas_q & acima);
    assign bus.pedido_abaixo   = |(chamadas_q & abaixo);
    assign bus.pedido_aqui     = |(chamadas_q & aqui);
endmodule

// File: tb/tb_registro_chamadas.sv
// Directed bench for registro_chamadas with hand-computed expectations.
module tb_registro_chamadas;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    registro_chamadas_if #(.N_ANDARES(16)) bus ();

    registro_chamadas #(
        .N_ANDARES(16), .ANDAR_RESTRITO(6), .TEMPO_ACESSO(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.botao = '0; bus.checagem = 1'b0; bus.andar_atual = '0; bus.parada = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_chamadas", 32'(bus.chamadas), 32'h0);
        chk("rst_acesso", 32'(bus.acesso_liberado), 0);
        chk("rst_negado", 32'(bus.negado), 0);
        chk("rst_pendente", 32'(bus.pendente), 0);

        // 1: unrestricted press
        bus.botao = 16'h0004; tick(); bus.botao = '0;
        chk("t1_chamadas", 32'(bus.chamadas), 32'h0004);
        chk("t1_negado", 32'(bus.negado), 0);
        chk("t1_pendente", 32'(bus.pendente), 1);
        chk("t1_acima", 32'(bus.pedido_acima), 1);
        chk("t1_abaixo", 32'(bus.pedido_abaixo), 0);

        // 2: restricted press without auth
        bus.botao = 16'h0200; tick(); bus.botao = '0;
        chk("t2_chamadas", 32'(bus.chamadas), 32'h0004);
        chk("t2_negado", 32'(bus.negado), 1);
        tick();
        chk("t2_negado_pulse", 32'(bus.negado), 0);

        // 3: checagem, press restricted three cycles later
        bus.checagem = 1'b1; tick(); bus.checagem = 1'b0;
        chk("t3_acesso", 32'(bus.acesso_liberado), 1);
        tick(); tick();
        bus.botao = 16'h0200; tick(); bus.botao = '0;
        chk("t3_chamadas", 32'(bus.chamadas), 32'h0204);
        chk("t3_acesso_drop", 32'(bus.acesso_liberado), 0);
        chk("t3_negado", 32'(bus.negado), 0);

        // 4: window expires after exactly 8 cycles
        bus.checagem = 1'b1; tick(); bus.checagem = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t4_acesso_%0d", k), 32'(bus.acesso_liberado), 1);
            tick();
        end
        chk("t4_acesso_off", 32'(bus.acesso_liberado), 0);
        bus.botao = 16'h1000; tick(); bus.botao = '0;
        chk("t4_negado", 32'(bus.negado), 1);
        chk("t4_chamadas", 32'(bus.chamadas), 32'h0204);

        // same-cycle bypass: press with checagem in OCIOSO, window stays shut
        bus.botao = 16'h0400; bus.checagem = 1'b1; tick();
        bus.botao = '0; bus.checagem = 1'b0;
        chk("byp_chamadas", 32'(bus.chamadas), 32'h0604);
        chk("byp_acesso", 32'(bus.acesso_liberado), 0);
        chk("byp_negado", 32'(bus.negado), 0);

        // build chamadas = 0210
        bus.andar_atual = 4'd2; bus.parada = 1'b1; tick();
        chk("clr2", 32'(bus.chamadas), 32'h0600);
        bus.andar_atual = 4'd10; tick();
        chk("clr10", 32'(bus.chamadas), 32'h0200);
        bus.parada = 1'b0; bus.botao = 16'h0010; tick(); bus.botao = '0;
        chk("set4", 32'(bus.chamadas), 32'h0210);

        // 5: clear beats set at andar 4
        bus.andar_atual = 4'd4; bus.parada = 1'b1; bus.botao = 16'h0010; tick();
        bus.parada = 1'b0; bus.botao = '0;
        chk("t5_chamadas", 32'(bus.chamadas), 32'h0200);
        chk("t5_acima", 32'(bus.pedido_acima), 1);
        chk("t5_abaixo", 32'(bus.pedido_abaixo), 0);
        chk("t5_aqui", 32'(bus.pedido_aqui), 0);
        bus.andar_atual = 4'd9; #1;
        chk("aqui9", 32'(bus.pedido_aqui), 1);
        chk("acima9", 32'(bus.pedido_acima), 0);
        bus.andar_atual = 4'd12; #1;
        chk("abaixo12", 32'(bus.pedido_abaixo), 1);
        chk("acima12", 32'(bus.pedido_acima), 0);

        // several restricted presses in one authorized cycle
        bus.checagem = 1'b1; tick(); bus.checagem = 1'b0;
        bus.botao = 16'h4080; tick(); bus.botao = '0;
        chk("multi_chamadas", 32'(bus.chamadas), 32'h4280);
        chk("multi_acesso", 32'(bus.acesso_liberado), 0);

        // 6: reset mid-window with calls pending, press in reset cycle dropped
        bus.checagem = 1'b1; tick(); bus.checagem = 1'b0;
        chk("t6_acesso_pre", 32'(bus.acesso_liberado), 1);
        rst = 1'b1; bus.botao = 16'h0080; tick();
        rst = 1'b0; bus.botao = '0;
        chk("t6_chamadas", 32'(bus.chamadas), 32'h0);
        chk("t6_acesso", 32'(bus.acesso_liberado), 0);
        chk("t6_negado", 32'(bus.negado), 0);
        chk("t6_pendente", 32'(bus.pendente), 0);
        tick();
        chk("t6_dropped", 32'(bus.chamadas), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
